// File: rtl/carry_less_divide.sv
// Iterative GF(2) polynomial divider: a = clmul(q, b) ^ r with deg(r) < deg(b).
// Consumes BITS_PER_CYCLE dividend bits per clock behind a valid/ready handshake.
module carry_less_divide #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                gecerli_i,
    output logic                hazir_o,
    input  logic [2*XLEN-1:0]   bolunen_i,
    input  logic [XLEN-1:0]     bolen_i,
    input  logic                iptal_i,
    output logic                gecerli_o,
    input  logic                hazir_i,
    output logic [2*XLEN-1:0]   bolum_o,
    output logic [XLEN-1:0]     kalan_o,
    output logic                sifir_bolme_o
);
    localparam int AW    = 2 * XLEN;
    localparam int N     = AW / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam int D_W   = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {BOS, HESAPLA, BITTI} state_t;
    state_t r_state, w_state_nxt;

    logic [AW-1:0]   r_a, r_q, r_bolum, w_q_nxt;
    logic [XLEN-1:0] r_b, r_rem, r_kalan, w_rem_nxt;
    logic [XLEN:0]   w_t;
    logic            w_qbit;
    logic [D_W-1:0]  r_d, w_msb;
    logic [CNT_W-1:0] r_cnt;
    logic            r_sifir;
    logic            w_accept, w_last, w_b_zero;

    assign hazir_o       = (r_state == BOS);
    assign gecerli_o     = (r_state == BITTI);
    assign bolum_o       = r_bolum;
    assign kalan_o       = r_kalan;
    assign sifir_bolme_o = r_sifir;

    // A flush in the same cycle as a request drops the request.
    assign w_accept = gecerli_i && hazir_o && !iptal_i;
    assign w_b_zero = (bolen_i == '0);
    assign w_last   = (r_cnt == CNT_W'(1));

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (bolen_i[i]) w_msb = D_W'(i);
        end
    end

    // Bits of R at and above d stay zero, so t never needs more than XLEN+1 bits.
    always_comb begin
        w_rem_nxt = r_rem;
        w_q_nxt   = r_q;
        w_t       = '0;
        w_qbit    = 1'b0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_t    = {w_rem_nxt, r_a[AW-1-k]};
            w_qbit = w_t[r_d];
            if (w_qbit) w_t = w_t ^ {1'b0, r_b};
            w_rem_nxt = w_t[XLEN-1:0];
            w_q_nxt   = {w_q_nxt[AW-2:0], w_qbit};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOS:     if (w_accept) w_state_nxt = w_b_zero ? BITTI : HESAPLA;
            HESAPLA: if (w_last) w_state_nxt = BITTI;
            BITTI:   if (hazir_i) w_state_nxt = BOS;
            default: w_state_nxt = BOS;
        endcase
        if (iptal_i) w_state_nxt = BOS;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= BOS;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_bolum <= '0;
            r_kalan <= '0;
            r_sifir <= 1'b0;
        end else if (iptal_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                BOS: begin
                    if (w_accept && w_b_zero) begin
                        r_bolum <= '0;
                        r_kalan <= bolunen_i[XLEN-1:0];
                        r_sifir <= 1'b1;
                    end else if (w_accept) begin
                        r_cnt <= CNT_W'(N);
                    end
                end
                HESAPLA: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bolum <= w_q_nxt;
                        r_kalan <= w_rem_nxt;
                        r_sifir <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_a   <= bolunen_i;
            r_b   <= bolen_i;
            r_d   <= w_msb;
            r_rem <= '0;
            r_q   <= '0;
        end else if (r_state == HESAPLA) begin
            r_a   <= r_a << BITS_PER_CYCLE;
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
        end
    end
endmodule

// File: tb/tb_carry_less_divide.sv
// Bench for carry_less_divide: three instances (1, 2 and 4 bits per cycle) share
// stimulus; only the selected instance sees requests and is observed.
module tb_carry_less_divide;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        gv_i, hz_i, ip_i;
    logic [63:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  sel;

    logic [2:0]  hz_o_a, gv_o_a, z_o_a;
    logic [63:0] q_o_a [3];
    logic [31:0] r_o_a [3];

    logic        hz_o, gv_o, z_o;
    logic [63:0] q_o;
    logic [31:0] r_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        carry_less_divide #(.XLEN(32), .BITS_PER_CYCLE(1 << k)) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .gecerli_i    (gv_i && (sel == 2'(k))),
            .hazir_o      (hz_o_a[k]),
            .bolunen_i    (a_i),
            .bolen_i      (b_i),
            .iptal_i      (ip_i),
            .gecerli_o    (gv_o_a[k]),
            .hazir_i      (hz_i),
            .bolum_o      (q_o_a[k]),
            .kalan_o      (r_o_a[k]),
            .sifir_bolme_o(z_o_a[k])
        );
    end

    always_comb begin
        hz_o = hz_o_a[sel];
        gv_o = gv_o_a[sel];
        z_o  = z_o_a[sel];
        q_o  = q_o_a[sel];
        r_o  = r_o_a[sel];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: polynomial product over GF(2) and polynomial degree.
    function automatic logic [95:0] clmul(input logic [63:0] q, input logic [31:0] b);
        logic [95:0] p = '0;
        for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, q} << i);
        return p;
    endfunction

    function automatic int deg(input logic [31:0] v);
        int d = -1;
        for (int i = 0; i < 32; i++) if (v[i]) d = i;
        return d;
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [31:0] b, input int stall,
                         output logic [63:0] q, output logic [31:0] r,
                         output logic z, output int lat);
        @(negedge clk);
        a_i = a; b_i = b; gv_i = 1'b1; hz_i = 1'b0;
        @(posedge clk); #1;
        gv_i = 1'b0;
        a_i  = {$urandom, $urandom};
        b_i  = $urandom;
        lat  = 0;
        while (!gv_o && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        q = q_o; r = r_o; z = z_o;
        repeat (stall) @(posedge clk);
        @(negedge clk) hz_i = 1'b1;
        @(posedge clk); #1;
        hz_i = 1'b0;
        chk("consume_drop", gv_o, 1'b0);
    endtask

    initial begin
        logic [63:0] q, a;
        logic [31:0] r, b;
        logic        z, seen;
        int          lat, exp_lat;

        sel = 0; gv_i = 0; hz_i = 0; ip_i = 0; a_i = '0; b_i = '0;
        rst_n = 1'b0;
        #23;
        chk("rst_hazir", hz_o, 1'b1);
        chk("rst_gecerli", gv_o, 1'b0);
        chk("rst_bolum", q_o, 64'h0);
        chk("rst_kalan", r_o, 32'h0);
        chk("rst_sifir", z_o, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        do_op(64'h5, 32'h3, 0, q, r, z, lat);
        chk("k1_q", q, 64'h3); chk("k1_r", r, 32'h0); chk("k1_z", z, 1'b0);
        chk("k1_lat", lat, 64);
        do_op(64'h7, 32'h3, 1, q, r, z, lat);
        chk("k2_q", q, 64'h2); chk("k2_r", r, 32'h1);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 0, q, r, z, lat);
        chk("k3_q", q, 64'h1_FFFF_FFFF); chk("k3_r", r, 32'h7FFF_FFFF);
        do_op(64'h1234_5678_9ABC_DEF0, 32'h1, 2, q, r, z, lat);
        chk("k4_q", q, 64'h1234_5678_9ABC_DEF0); chk("k4_r", r, 32'h0);

        do_op(64'hDEAD_BEEF_0000_0042, 32'h0, 0, q, r, z, lat);
        chk("dz_lat", lat, 0);
        chk("dz_q", q, 64'h0); chk("dz_r", r, 32'h42); chk("dz_z", z, 1'b1);

        // Backpressure: result must hold for 10 stalled cycles.
        @(negedge clk) a_i = 64'h7; b_i = 32'h3; gv_i = 1'b1;
        @(posedge clk); #1 gv_i = 1'b0;
        lat = 0;
        while (!gv_o && lat < 300) begin @(posedge clk); #1 lat++; end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_gv", gv_o, 1'b1); chk("bp_q", q_o, 64'h2);
            chk("bp_r", r_o, 32'h1);  chk("bp_hz", hz_o, 1'b0);
        end
        @(negedge clk) hz_i = 1'b1;
        chk("bp_hz_consume", hz_o, 1'b0);
        @(posedge clk); #1 hz_i = 1'b0;
        chk("bp_consumed", gv_o, 1'b0);
        chk("bp_q_kept", q_o, 64'h2);

        // Flush at edge 20 of compute.
        @(negedge clk) a_i = {$urandom, $urandom}; b_i = 32'h3; gv_i = 1'b1;
        @(posedge clk); #1 gv_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk) ip_i = 1'b1;
        @(posedge clk); #1;
        chk("fl_hz", hz_o, 1'b1); chk("fl_gv", gv_o, 1'b0);
        @(negedge clk) ip_i = 1'b0;
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1 if (gv_o) seen = 1'b1; end
        chk("fl_no_pulse", seen, 1'b0);
        do_op(64'h5, 32'h3, 0, q, r, z, lat);
        chk("fl_after_q", q, 64'h3); chk("fl_after_r", r, 32'h0);

        // Flush together with a request: request dropped.
        @(negedge clk) a_i = 64'h5; b_i = 32'h3; gv_i = 1'b1; ip_i = 1'b1;
        @(posedge clk); #1;
        chk("fl_drop", hz_o, 1'b1);
        gv_i = 1'b0; ip_i = 1'b0;

        // Asynchronous reset mid-compute.
        @(negedge clk) a_i = 64'h5; b_i = 32'h3; gv_i = 1'b1;
        @(posedge clk); #1 gv_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("ar_gv", gv_o, 1'b0); chk("ar_hz", hz_o, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        // Random operands against the algebraic definition, per width.
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            exp_lat = 64 >> s;
            for (int n = 0; n < 150; n++) begin
                a = {$urandom, $urandom};
                b = $urandom >> $urandom_range(0, 31);
                if (b == 0) b = 32'h1;
                do_op(a, b, int'($urandom_range(0, 3)), q, r, z, lat);
                chk("rnd_prod", clmul(q, b) ^ {64'b0, r}, {32'b0, a});
                chk("rnd_deg", deg(r) < deg(b), 1'b1);
                chk("rnd_lat", lat, exp_lat);
                chk("rnd_z", z, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/carry_less_divide.md
Name: carry_less_divide

Overview:
- Iterative GF(2) polynomial divider; the inverse of the carry-less multiply unit in the execute stage.
- Given a 2*XLEN-bit dividend a and an XLEN-bit divisor b, it produces the quotient q and the remainder r such that clmul(q, b) XOR r == a, with deg(r) < deg(b).
- Sits beside the multiplier in the execute stage as a multi-cycle unit behind a valid/ready handshake, with a pipeline-flush input.

Parameters:
- XLEN, 32, divisor/remainder width; dividend and quotient are 2*XLEN.
- BITS_PER_CYCLE, 1, dividend bits consumed per clock. Legal values are 1, 2 and 4, and the value must divide 2*XLEN.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- gecerli_i  input  1  request valid.
- hazir_o  output  1  unit ready to accept a request.
- bolunen_i  input  2*XLEN  dividend polynomial a.
- bolen_i  input  XLEN  divisor polynomial b.
- iptal_i  input  1  flush; aborts any operation in flight.
- gecerli_o  output  1  result valid.
- hazir_i  input  1  consumer ready.
- bolum_o  output  2*XLEN  quotient q.
- kalan_o  output  XLEN  remainder r.
- sifir_bolme_o  output  1  divisor was zero; qualified by gecerli_o.

Behaviour:
- Reset (async, rst_ni=0):
  - state=BOS; hazir_o=1; gecerli_o=0.
  - bolum_o=0; kalan_o=0; sifir_bolme_o=0.
  - Internal counter cleared.
- Handshake rules:
  - A request is accepted on an edge where gecerli_i && hazir_o.
  - A result is consumed on an edge where gecerli_o && hazir_i.
  - hazir_o=1 only in BOS.
  - gecerli_o=1 only in BITTI.
- States: BOS (idle), HESAPLA (compute), BITTI (result held).
- BOS:
  - On accept, latch a and b.
  - Compute d = index of the most significant set bit of b (priority encoder).
  - Clear R (XLEN bits) and q; set counter N = 2*XLEN/BITS_PER_CYCLE.
  - If b==0: go to BITTI with q=0, r=a[XLEN-1:0], sifir_bolme_o=1.
  - Otherwise: go to HESAPLA.
- HESAPLA, per iteration (BITS_PER_CYCLE iterations chained combinationally each edge):
  - Take dividend bits MSB first, bit i = 2*XLEN-1 down to 0.
  - t = {R, a[i]} (XLEN+1 bits).
  - qbit = t[d].
  - If qbit, t = t XOR b (zero-extended).
  - R = t[XLEN-1:0]; q = {q[2*XLEN-2:0], qbit}.
  - Invariant: bits of R at index >= d are zero after every iteration.
  - Counter decrements once per edge; on the edge where it reaches 0, go to BITTI and register q and R onto the outputs.
- Latency:
  - b != 0: gecerli_o rises after exactly 2*XLEN/BITS_PER_CYCLE edges following the accepting edge. Default is 64 edges.
  - b == 0: gecerli_o rises after 1 edge.
- BITTI:
  - Outputs are held stable while hazir_i=0.
  - On consume, go to BOS; gecerli_o drops on the same edge; bolum_o/kalan_o keep their last values.
  - No new request is accepted in the consume cycle (hazir_o=0 there). Back-to-back throughput is one op per N+2 cycles.
- Special divisors:
  - b==1 (d=0): q=a, r=0.
  - b with bit XLEN-1 set: d=XLEN-1, and R never overflows XLEN bits.
- iptal_i:
  - Has highest priority in every state. On the edge it is sampled high, state goes to BOS, gecerli_o=0, and the counter is cleared.
  - Output data registers are not required to clear.
  - If iptal_i and gecerli_i are both high in BOS, the request is dropped, not accepted.
- Mid-operation changes on bolunen_i/bolen_i after accept have no effect, because the operands are latched.
- Widths: all arithmetic is XOR only; no carries; no sign handling.

Test Plan:
- Known values, each accepted from BOS:
  - a=0x5, b=0x3 -> q=0x3, r=0x0, sifir_bolme_o=0, gecerli_o exactly 64 edges after accept.
  - a=0x7, b=0x3 -> q=0x2, r=0x1.
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0x8000_0000 -> q=0x1_FFFF_FFFF, r=0x7FFF_FFFF.
  - a=0x1234_5678_9ABC_DEF0, b=0x1 -> q=0x1234_5678_9ABC_DEF0, r=0.
- Divide by zero: a=0xDEAD_BEEF_0000_0042, b=0 -> after 1 edge gecerli_o=1, q=0, r=0x0000_0042, sifir_bolme_o=1.
- Backpressure: hold hazir_i=0 for 10 cycles in BITTI -> gecerli_o, bolum_o and kalan_o are stable; hazir_o=0 throughout; the result is consumed on the first edge with hazir_i=1.
- Flush: assert iptal_i at edge 20 of HESAPLA -> next cycle state=BOS, hazir_o=1, no gecerli_o pulse. A following request a=0x5, b=0x3 completes correctly. Also apply reset (rst_ni low) mid-HESAPLA -> gecerli_o=0 and hazir_o=1 immediately, asynchronously.
- Random self-check: 10k random (a, b != 0) with random hazir_i stalls, at BITS_PER_CYCLE = 1, 2 and 4 -> clmul(q, b) XOR r == a, deg(r) < deg(b), latency = 64/BITS_PER_CYCLE.
